// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard/stall controller: sequences load-use stalls, branch flushes, LM/SM busy and halt.
// Optional saturating STALL/FLUSH cycle counters are enabled with `define STALL_PERF_CNT_EN.
module pipeline_stall_controller #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             should_stall,
  input  logic             branch_taken_ex,
  input  logic             multi_busy,
  input  logic             halt_rr,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_rr_we,
  output logic             id_rr_bubble,
  output logic             rr_ex_flush,
  output logic [1:0]       state
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
`endif
);

  localparam logic [1:0] StRun   = 2'b00;
  localparam logic [1:0] StStall = 2'b01;
  localparam logic [1:0] StFlush = 2'b10;
  localparam logic [1:0] StHalt  = 2'b11;

  // The branch cycle is itself the first bubble, so FLUSH lasts FLUSH_CYCLES-1 cycles.
  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_rr_we     = 1'b0;
    id_rr_bubble = 1'b0;
    rr_ex_flush  = 1'b0;
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;

    if (rst) begin
      state_d     = StRun;
      flush_cnt_d = '0;
    end else if (state_q == StHalt) begin
      state_d = StHalt;
    end else if (branch_taken_ex) begin
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      if_id_flush  = 1'b1;
      id_rr_we     = 1'b1;
      id_rr_bubble = 1'b1;
      rr_ex_flush  = 1'b1;
      flush_cnt_d  = FlushLoad;
      state_d      = (FLUSH_CYCLES > 1) ? StFlush : StRun;
    end else if (state_q == StFlush) begin
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      id_rr_we     = 1'b1;
      id_rr_bubble = 1'b1;
      if (flush_cnt_q > 3'd1) begin
        flush_cnt_d = flush_cnt_q - 3'd1;
        state_d     = StFlush;
      end else begin
        flush_cnt_d = '0;
        state_d     = StRun;
      end
    end else if (halt_rr) begin
      // Freeze the front end; the halt instruction parks in RR.
      state_d = StHalt;
    end else if (should_stall) begin
      id_rr_we     = 1'b1;
      id_rr_bubble = 1'b1;
      state_d      = StStall;
    end else if (multi_busy) begin
      id_rr_we = 1'b1;
      state_d  = StRun;
    end else begin
      pc_we    = 1'b1;
      if_id_we = 1'b1;
      id_rr_we = 1'b1;
      state_d  = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state = state_q;

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      flush_perf_q <= '0;
    end else begin
      if (state_q == StStall && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (state_q == StFlush && flush_perf_q != '1) begin
        flush_perf_q <= flush_perf_q + 1'b1;
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_perf_q;
`endif

endmodule
